// File: rtl/sym_check_scheduler_if.sv
// Requester/result/statistics bundle for sym_check_scheduler.
// The slave side belongs to the scheduler; the master side to whoever drives it.
interface sym_check_scheduler_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req0_valid;
  logic [7:0]       req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_data;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_src;
  logic             res_sym;
  logic [2:0]       res_mismatch;
  logic             res_near;
  logic             clr;
  logic [CNT_W-1:0] sym_count;
  logic [CNT_W-1:0] total_count;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, res_ready, clr,
    output req0_ready, req1_ready, res_valid, res_src, res_sym, res_mismatch, res_near,
    output sym_count, total_count
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, res_ready, clr,
    input  req0_ready, req1_ready, res_valid, res_src, res_sym, res_mismatch, res_near,
    input  sym_count, total_count
  );
endinterface

// File: rtl/sym_check_scheduler.sv
// Two-requester round-robin front end for a shared byte-symmetry checker, with a
// single registered result slot and saturating symmetric/total statistics.
module sym_check_scheduler #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned NEAR_THRESH = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  sym_check_scheduler_if.slave  bus
);

  localparam logic [2:0]       NearThr = 3'(NEAR_THRESH);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic {StEmpty, StFull} slot_e;

  slot_e            r_state, w_state_d;
  logic             w_res_valid, w_can_accept;
  logic             w_grant0, w_grant1, w_accept;
  logic             r_last_grant;
  logic [7:0]       w_data;
  logic [3:0]       w_pair;
  logic [2:0]       w_mis;
  logic             w_sym, w_near;
  logic             r_src, r_sym, r_near;
  logic [2:0]       r_mis;
  logic [CNT_W-1:0] r_sym_cnt, r_tot_cnt;

  // Slot FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StEmpty;
    else        r_state <= w_state_d;
  end

  // Slot FSM: next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty: if (w_accept) w_state_d = StFull;
      StFull:  if (bus.res_ready && !w_accept) w_state_d = StEmpty;
    endcase
  end

  // Slot FSM: outputs; readies are held low for the whole of reset
  always_comb begin
    w_res_valid  = (r_state == StFull);
    w_can_accept = rst_n && (!w_res_valid || bus.res_ready);
  end

  // r_last_grant names the previous winner, so contention goes to the other one
  always_comb begin
    w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    w_accept = w_can_accept && (w_grant0 || w_grant1);
    w_data   = w_grant1 ? bus.req1_data : bus.req0_data;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_pair[k] = w_data[k] ^ w_data[7-k];
    end
    w_mis  = {2'b00, w_pair[0]} + {2'b00, w_pair[1]} + {2'b00, w_pair[2]} + {2'b00, w_pair[3]};
    w_sym  = (w_mis == 3'd0);
    w_near = (w_mis <= NearThr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_src        <= 1'b0;
      r_sym        <= 1'b0;
      r_mis        <= 3'd0;
      r_near       <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
      r_src        <= w_grant1;
      r_sym        <= w_sym;
      r_mis        <= w_mis;
      r_near       <= w_near;
    end
  end

  // clr beats a same-cycle accept: the byte is delivered but not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_cnt <= '0;
      r_tot_cnt <= '0;
    end else if (bus.clr) begin
      r_sym_cnt <= '0;
      r_tot_cnt <= '0;
    end else if (w_accept) begin
      if (r_tot_cnt != CntMax)          r_tot_cnt <= r_tot_cnt + 1'b1;
      if (w_sym && r_sym_cnt != CntMax) r_sym_cnt <= r_sym_cnt + 1'b1;
    end
  end

  assign bus.req0_ready   = w_can_accept && w_grant0;
  assign bus.req1_ready   = w_can_accept && w_grant1;
  assign bus.res_valid    = w_res_valid;
  assign bus.res_src      = r_src;
  assign bus.res_sym      = r_sym;
  assign bus.res_mismatch = r_mis;
  assign bus.res_near     = r_near;
  assign bus.sym_count    = r_sym_cnt;
  assign bus.total_count  = r_tot_cnt;

endmodule

// File: tb/tb_sym_check_scheduler.sv
// Bench for sym_check_scheduler: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_sym_check_scheduler;

  localparam int CNT_W = 3;
  localparam int NEAR  = 1;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sym_check_scheduler_if #(.CNT_W(CNT_W)) bus ();

  sym_check_scheduler #(.CNT_W(CNT_W), .NEAR_THRESH(NEAR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: count mismatching mirror pairs directly
  function automatic int mism(input logic [7:0] d);
    int n = 0;
    for (int k = 0; k < 4; k++) if (d[k] != d[7-k]) n++;
    return n;
  endfunction

  int m_valid, m_src, m_mis, m_last, m_sym_cnt, m_tot_cnt;

  function automatic int winner();
    if (bus.req0_valid && bus.req1_valid) return (m_last == 0) ? 1 : 0;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  function automatic int can_take();
    return (m_valid == 0 || bus.res_ready) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_src = 0; m_mis = 0; m_last = 1; m_sym_cnt = 0; m_tot_cnt = 0;
    end else begin
      int w;
      w = winner();
      if (can_take() != 0 && w >= 0) begin
        m_mis   = mism(w == 1 ? bus.req1_data : bus.req0_data);
        m_valid = 1;
        m_src   = w;
        m_last  = w;
        if (!bus.clr) begin
          if (m_tot_cnt < MAXC) m_tot_cnt++;
          if (m_mis == 0 && m_sym_cnt < MAXC) m_sym_cnt++;
        end
      end else if (bus.res_ready) begin
        m_valid = 0;
      end
      if (bus.clr) begin
        m_sym_cnt = 0;
        m_tot_cnt = 0;
      end
    end
  end

  // Per-cycle compare, on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_res_valid", int'(bus.res_valid), 0);
      chk("rst_req0_ready", int'(bus.req0_ready), 0);
      chk("rst_req1_ready", int'(bus.req1_ready), 0);
    end else begin
      int w;
      w = winner();
      chk("res_valid", int'(bus.res_valid), m_valid);
      if (m_valid != 0) begin
        chk("res_src", int'(bus.res_src), m_src);
        chk("res_mismatch", int'(bus.res_mismatch), m_mis);
        chk("res_sym", int'(bus.res_sym), (m_mis == 0) ? 1 : 0);
        chk("res_near", int'(bus.res_near), (m_mis <= NEAR) ? 1 : 0);
      end
      chk("req0_ready", int'(bus.req0_ready), (can_take() != 0 && w == 0) ? 1 : 0);
      chk("req1_ready", int'(bus.req1_ready), (can_take() != 0 && w == 1) ? 1 : 0);
      chk("sym_count", int'(bus.sym_count), m_sym_cnt);
      chk("total_count", int'(bus.total_count), m_tot_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
    bus.res_ready  = 1'b1; bus.clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic exp_res(input string name, input int src, input int sym, input int mis,
                         input int near);
    chk({name, "_valid"}, int'(bus.res_valid), 1);
    chk({name, "_src"}, int'(bus.res_src), src);
    chk({name, "_sym"}, int'(bus.res_sym), sym);
    chk({name, "_mis"}, int'(bus.res_mismatch), mis);
    chk({name, "_near"}, int'(bus.res_near), near);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    #2;
    chk("reset_ready0", int'(bus.req0_ready), 0);
    chk("reset_total", int'(bus.total_count), 0);
    step();
    idle_inputs();
    do_reset();

    // Single requester: 0x81 then 0x01
    bus.req0_valid = 1'b1; bus.req0_data = 8'h81;
    step();
    exp_res("t1_81", 0, 1, 0, 1);
    bus.req0_data = 8'h01;
    step();
    exp_res("t1_01", 0, 0, 1, 1);
    chk("t1_total", int'(bus.total_count), 2);
    chk("t1_sym", int'(bus.sym_count), 1);
    bus.req0_valid = 1'b0;

    // Requester 1: 0x0F then 0xFF
    bus.req1_valid = 1'b1; bus.req1_data = 8'h0F;
    step();
    exp_res("t2_0f", 1, 0, 4, 0);
    bus.req1_data = 8'hFF;
    step();
    exp_res("t2_ff", 1, 1, 0, 1);
    bus.req1_valid = 1'b0;
    step();

    // Contention after reset: grants alternate starting with requester 0
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h18;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_src", int'(bus.res_src), i % 2);
    end
    chk("t3_total", int'(bus.total_count), 4);
    chk("t3_sym", int'(bus.sym_count), 4);
    idle_inputs();
    step();

    // Backpressure: held result stays stable, then drain+refill in one cycle
    bus.res_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA5;
    step();
    bus.req0_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      chk("t4_ready_low", int'(bus.req0_ready), 0);
      exp_res("t4_hold", 0, 1, 0, 1);
      step();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("t4_ready_high", int'(bus.req0_ready), 1);
    step();
    exp_res("t4_5a", 0, 1, 0, 1);
    idle_inputs();
    step();

    // Saturation at 7, then clr beats a simultaneous accept
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h81;
    for (int i = 0; i < 10; i++) step();
    chk("t5_total_sat", int'(bus.total_count), 7);
    chk("t5_sym_sat", int'(bus.sym_count), 7);
    bus.clr = 1'b1; bus.req0_data = 8'h01;
    step();
    chk("t5_clr_total", int'(bus.total_count), 0);
    chk("t5_clr_sym", int'(bus.sym_count), 0);
    exp_res("t5_clr_res", 0, 0, 1, 1);
    idle_inputs();
    step();

    // Async reset while a result is held
    bus.res_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h0F;
    step();
    chk("t6_held", int'(bus.res_valid), 1);
    bus.req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(bus.res_valid), 0);
    chk("t6_async_total", int'(bus.total_count), 0);
    step();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b1; bus.req1_data = 8'hFF;
    step();
    chk("t6_first_grant", int'(bus.res_src), 0);
    idle_inputs();
    step();

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req0_data  = 8'($urandom);
      bus.req1_data  = ($urandom_range(0, 3) == 0) ? 8'h66 : 8'($urandom);
      bus.res_ready  = ($urandom_range(0, 2) != 0);
      bus.clr        = ($urandom_range(0, 40) == 0);
      rst_n          = ($urandom_range(0, 300) != 0);
      step();
    end
    rst_n = 1'b1;
    idle_inputs();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
